// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART receiver.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115_200;
    localparam int OVERSAMPLE       = 16;
    localparam int DATA_BITS        = 8;

    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

    // Rounded clocks-per-oversample-tick.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks,
// with a synchronous restart that realigns the phase to a start edge.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (restart || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampled UART receiver (8N1) with sticky rdy/frame_err/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err flag.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic                 clk_50_mhz,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] dout,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic fall, restart, tick, byte_ok;

    rx_state_t state_q, state_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 done_q, done_d;
    logic                 stop_ok_q, stop_ok_d;
    logic                 rdy_q, rdy_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign fall    = rx_prev_q & ~rx_sync_q;
    assign restart = (state_q == IDLE) && fall;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk_50_mhz),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk_50_mhz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (fall) state_d = START;
            START:  if (tick && tick_cnt_q == TICK_MID) state_d = rx_sync_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (tick && tick_cnt_q == TICK_LAST && bit_cnt_q == BIT_LAST) state_d = PARITY;
            PARITY: if (tick && tick_cnt_q == TICK_LAST) state_d = STOP;
`else
            DATA:   if (tick && tick_cnt_q == TICK_LAST && bit_cnt_q == BIT_LAST) state_d = STOP;
`endif
            STOP:   if (tick && tick_cnt_q == TICK_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sampling datapath; the stop-bit result is registered so flags update one cycle later.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        stop_ok_d  = stop_ok_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d  = 1'b0;
`endif
            end
            START: if (tick) tick_cnt_d = (tick_cnt_q == TICK_MID) ? 4'd0 : tick_cnt_q + 4'd1;
            DATA: if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == TICK_LAST) begin
                    shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == TICK_LAST) par_bad_d = rx_sync_q ^ (^shift_q);
            end
`endif
            STOP: if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == TICK_LAST) begin
                    done_d    = 1'b1;
                    stop_ok_d = rx_sync_q;
                end
            end
            default: ;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign byte_ok = ~par_bad_q;
`else
    assign byte_ok = 1'b1;
`endif

    // A clear and a new byte in the same cycle: the clear goes first, the event wins.
    always_comb begin
        rdy_d       = rdy_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (rdy_clr) begin
            rdy_d       = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (done_q) begin
            if (!stop_ok_q) begin
                frame_err_d = 1'b1;
            end else if (byte_ok) begin
                dout_d = shift_q;
                rdy_d  = 1'b1;
                if (rdy_q && !rdy_clr) overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50_mhz or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            stop_ok_q   <= 1'b0;
            rdy_q       <= 1'b0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            stop_ok_q   <= stop_ok_d;
            rdy_q       <= rdy_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_comb begin
        parity_err_d = parity_err_q;
        if (rdy_clr) parity_err_d = 1'b0;
        if (done_q && par_bad_q) parity_err_d = 1'b1;
    end

    always_ff @(posedge clk_50_mhz or posedge rst) begin
        if (rst) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rdy       = rdy_q;
    assign dout      = dout_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
